// File: rtl/quad_step_decoder.sv
// ============================================================================
// Module   : quad_step_decoder
// Function : Quadrature A/B decoder producing step pulses, direction and a
//            wrapping position count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module quad_step_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             QuadA,
    input  logic             QuadB,
    input  logic             Clear,
    output logic [WIDTH-1:0] Count,
    output logic             UpOrDown,
    output logic             Step,
    output logic             Error
);

    localparam int PRIME_EDGES = SYNC_STAGES + 1;
    localparam int PRIME_W     = $clog2(PRIME_EDGES + 1);
    localparam logic [PRIME_W-1:0] PRIME_DONE = PRIME_W'(PRIME_EDGES);

    logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
    logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
    logic [1:0]             prev_q, prev_d;
    logic [PRIME_W-1:0]     prime_q, prime_d;
    logic [WIDTH-1:0]       count_q, count_d;
    logic                   dir_q, dir_d;
    logic                   step_q, step_d;
    logic                   err_q, err_d;

    logic [1:0] cur;
    logic [1:0] pos_cur;
    logic [1:0] pos_prev;
    logic [1:0] pos_delta;
    logic       primed;
    logic       fwd;
    logic       rev;
    logic       illegal;

    // Gray code 00,01,11,10 maps to ring positions 0..3
    function automatic logic [1:0] gray_to_pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    always_comb begin
        sync_a_d = {sync_a_q[SYNC_STAGES-2:0], QuadA};
        sync_b_d = {sync_b_q[SYNC_STAGES-2:0], QuadB};
    end

    assign cur       = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
    assign pos_cur   = gray_to_pos(cur);
    assign pos_prev  = gray_to_pos(prev_q);
    assign pos_delta = pos_cur - pos_prev;
    assign fwd       = (pos_delta == 2'd1);
    assign rev       = (pos_delta == 2'd3);
    assign illegal   = (pos_delta == 2'd2);
    assign primed    = (prime_q == PRIME_DONE);

    always_comb begin
        prev_d  = cur;
        prime_d = primed ? prime_q : prime_q + PRIME_W'(1);
        count_d = count_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = err_q;

        // Clear wins over any transition decoded in the same cycle
        if (Clear) begin
            count_d = '0;
            err_d   = 1'b0;
        end else if (primed) begin
            if (fwd) begin
                count_d = count_q + WIDTH'(1);
                dir_d   = 1'b1;
                step_d  = 1'b1;
            end else if (rev) begin
                count_d = count_q - WIDTH'(1);
                dir_d   = 1'b0;
                step_d  = 1'b1;
            end else if (illegal) begin
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            prev_q   <= '0;
            prime_q  <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync_a_q <= sync_a_d;
            sync_b_q <= sync_b_d;
            prev_q   <= prev_d;
            prime_q  <= prime_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
        end
    end

    assign Count    = count_q;
    assign UpOrDown = dir_q;
    assign Step     = step_q;
    assign Error    = err_q;

endmodule

`default_nettype wire

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature decoder that converts a pair of asynchronous A/B phase inputs into single-cycle step pulses, a direction flag, and a wrapping up/down position count. It is the front end that produces the up/down stimulus the existing up/down counter consumes, and it also keeps its own count so it can be checked standalone. It sits between off-chip encoder pins and the counter/display logic in the same clock domain.

## Interface

Parameters:
- WIDTH, 4: width of Count in bits; Count wraps modulo 2^WIDTH.
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer; legal values are 2 or more.

Ports:
- Clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; asserting it (0) clears all state immediately.
- QuadA, input, 1: encoder phase A; asynchronous to Clk.
- QuadB, input, 1: encoder phase B; asynchronous to Clk.
- Clear, input, 1: synchronous clear, active-high.
- Count, output, WIDTH: position count.
- UpOrDown, output, 1: direction of the last valid step; 1 = up, 0 = down.
- Step, output, 1: one-cycle pulse for each valid step.
- Error, output, 1: sticky flag set on an illegal transition.

## Operation

- **Reset values.** Count=0, UpOrDown=0, Step=0, Error=0. All synchronizer flops, the prev-state register, and the prime counter reset to 0.
- **Synchronizer.** Each input passes through its own SYNC_STAGES-deep chain. The decode logic uses only the final stage outputs, called cur = {A,B}.
- **prev register.** prev = {A,B} is loaded from cur on every edge while reset is deasserted.
- **Priming.** For the first SYNC_STAGES+1 rising edges after reset release:
  - prev tracks cur;
  - no step is evaluated;
  - Error cannot set.
  
  This prevents a false error when the inputs are not at 00 when reset is released.
- **Decode, once primed.** Transitions are judged by the sequence 00→01→11→10→00.
  - Forward transition (00→01, 01→11, 11→10, 10→00): Count+1, UpOrDown=1, Step=1.
  - Reverse transition (the opposite order): Count−1, UpOrDown=0, Step=1.
  - cur == prev: no change, Step=0.
  - Both bits changed (00↔11, 01↔10): Error=1 (sticky), Count unchanged, UpOrDown unchanged, Step=0.
- **Arithmetic.** Counting is modulo 2^WIDTH. For WIDTH=4, an up step from 15 gives 0 and a down step from 0 gives 15.
- **Clear.**
  - On the next edge: Count=0, Error=0, Step=0; UpOrDown holds its value.
  - Clear takes priority over a simultaneous step or error in the same cycle. That transition is discarded, and prev still updates to cur.
  - Clear does not restart priming.
- **Reset mid-operation.** Asserting reset at any time returns all state to reset values asynchronously, and priming restarts after release.

## Timing

- **Latency.** An input change that is stable before rising edge n updates Count, UpOrDown, Step and Error at edge n+SYNC_STAGES. That is 2 edges through the synchronizer and 1 registered decode edge, so 3 edges for SYNC_STAGES=2.
- **Registered outputs.** All outputs are registered. Step is high for exactly one cycle per valid step.
- **Back-to-back steps.** Consecutive valid steps on consecutive cycles produce Step on consecutive cycles. Each change must hold at least one Clk period for every step to be decoded.
- **Error timing.** Error asserts on the same edge the illegal transition would have been counted. It stays high until Clear or reset.

## Test plan

- **Reset and priming.** Hold QuadA=1, QuadB=1 through reset release, then keep them static for 10 cycles → Count=0, Error=0, Step never pulses.
- **Forward rotation.** From 00, apply 00→01→11→10→00, holding each state 4 cycles, repeated 5 times (20 steps) → 20 Step pulses, UpOrDown=1, Count wraps 15→0 and ends at 4. The first pulse arrives 3 edges after the first input change.
- **Reverse rotation.** From Count=0, apply 00→10→11→01→00 once → Count goes 15, 14, 13, 12; UpOrDown=0; 4 Step pulses.
- **Illegal transition.** Apply 00→11 after priming → Error=1 at +3 edges, Count unchanged, no Step. Then continue legal forward steps → Count increments while Error stays 1.
- **Clear collision.** Assert Clear for 1 cycle on the same edge a forward step decodes, with Count=7 and Error=1 → next values Count=0, Error=0, Step=0. A following legal step gives Count=1.
- **Mid-operation reset.** Assert reset for 1 cycle when Count=9 → Count=0 immediately, without waiting for a clock edge. The first step after release is honoured only after the 3-edge priming window.
